// File: rtl/wr_control.sv
// wr_control: write-side controller for the systolic-array output path.
// A start request launches a run of 2N-1 cycles. Column i writes during
// run cycles k = i .. i+N-1 at row base + (k - i). This de-skews the
// diagonal result wavefront so that every bank receives its N results at
// consecutive rows starting from the latched base address.
// All outputs are registered. They are computed from the next-state
// values, so they line up with the run cycle they describe.
// state_dbg exposes the FSM state (1 = RUN) for observation.
module wr_control #(
  parameter int width_height = 16,
  parameter int addr_width   = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               active,
  input  logic [addr_width-1:0]              base_addr,
  output logic [width_height-1:0]            wr_en,
  output logic [width_height*addr_width-1:0] wr_addr,
  output logic                               busy,
  output logic                               done,
  output logic                               state_dbg
);

  localparam int N  = width_height;
  localparam int AW = addr_width;
  localparam int KW = $clog2(2 * N) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 * N - 2);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [AW-1:0]     base_q, base_d;

  logic [N-1:0]      wr_en_d;
  logic [N*AW-1:0]   wr_addr_d;
  logic              busy_d;
  logic              done_d;
  logic [KW-1:0]     rel;

  // Next run state: start, advance, back-to-back restart or return to idle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    if (reset) begin
      state_d = S_IDLE;
      k_d     = '0;
      base_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (active) begin
            state_d = S_RUN;
            k_d     = '0;
            base_d  = base_addr;
          end
        end
        S_RUN: begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (active) begin
              // Restart with no idle gap.
              state_d = S_RUN;
              base_d  = base_addr;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // A start request in mid-run is ignored.
            k_d = k_q + KW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

  // Output values for the upcoming cycle, derived from the next run state.
  always_comb begin
    wr_en_d   = '0;
    wr_addr_d = '0;
    rel       = '0;
    busy_d    = (state_d == S_RUN);
    done_d    = (state_d == S_RUN) && (k_d == K_LAST);
    for (int i = 0; i < N; i++) begin
      // rel = k - i. If k < i it wraps to a value far above N, so one
      // unsigned compare covers both edges of the column's window.
      rel = k_d - KW'(i);
      if ((state_d == S_RUN) && (rel < KW'(N))) begin
        wr_en_d[i]             = 1'b1;
        wr_addr_d[i*AW +: AW]  = base_d + AW'(rel);
      end
    end
  end

  // Register the run state and every output.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    k_q     <= k_d;
    base_q  <= base_d;
    wr_en   <= wr_en_d;
    wr_addr <= wr_addr_d;
    busy    <= busy_d;
    done    <= done_d;
  end

  assign state_dbg = (state_q == S_RUN);

endmodule

// File: tb/tb_wr_control.sv
// Testbench for wr_control. Three instances run side by side, with
// N = 16, 4 and 2. A behavioural model tracks each run as a start cycle
// and base address. It predicts the outputs by counting the writes each
// column has already made.
module tb_wr_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       act [3];
  logic [7:0] bin [3];

  logic [15:0]  en16;
  logic [127:0] a16;
  logic [3:0]   en4;
  logic [31:0]  a4;
  logic [1:0]   en2;
  logic [15:0]  a2;
  logic         bz [3];
  logic         dn [3];
  logic         sd [3];

  int n_vec = 0;
  int n_err = 0;
  int nn [3] = '{16, 4, 2};

  wr_control #(.width_height(16), .addr_width(8)) dut16 (
    .clk(clk), .reset(rst[0]), .active(act[0]), .base_addr(bin[0]),
    .wr_en(en16), .wr_addr(a16), .busy(bz[0]), .done(dn[0]), .state_dbg(sd[0]));
  wr_control #(.width_height(4), .addr_width(8)) dut4 (
    .clk(clk), .reset(rst[1]), .active(act[1]), .base_addr(bin[1]),
    .wr_en(en4), .wr_addr(a4), .busy(bz[1]), .done(dn[1]), .state_dbg(sd[1]));
  wr_control #(.width_height(2), .addr_width(8)) dut2 (
    .clk(clk), .reset(rst[2]), .active(act[2]), .base_addr(bin[2]),
    .wr_en(en2), .wr_addr(a2), .busy(bz[2]), .done(dn[2]), .state_dbg(sd[2]));

  // ---------------- reference model ----------------
  // m_k counts the cycles since the run started. A run lasts 2N-1 cycles.
  // A start is accepted when no run is going on, or in the final cycle of a run.
  int         m_run [3];
  int         m_k   [3];
  logic [7:0] m_base[3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        m_run[d] = 0; m_k[d] = 0; m_base[d] = 8'h00;
      end else if (m_run[d] == 0 || m_k[d] == 2 * nn[d] - 2) begin
        if (act[d]) begin
          m_run[d] = 1; m_k[d] = 0; m_base[d] = bin[d];
        end else begin
          m_run[d] = 0; m_k[d] = 0;
        end
      end else begin
        m_k[d] = m_k[d] + 1;
      end
    end
  end

  // Expected {busy, done, wr_en[15:0], wr_addr[127:0]}. Column i has
  // made w = k - i writes so far. It writes while 0 <= w < N, at row base + w.
  function automatic logic [145:0] expect_vec(input int d);
    logic [15:0]  e;
    logic [127:0] a;
    logic         dn_e;
    int           w;
    e = '0; a = '0; dn_e = 1'b0;
    if (m_run[d] != 0) begin
      for (int i = 0; i < nn[d]; i++) begin
        w = m_k[d] - i;
        if (w >= 0 && w < nn[d]) begin
          e[i] = 1'b1;
          a[i*8 +: 8] = m_base[d] + 8'(w);
        end
      end
      // The run ends when the last column makes its N-th write.
      dn_e = (m_k[d] - (nn[d] - 1) == nn[d] - 1);
    end
    return {(m_run[d] != 0), dn_e, e, a};
  endfunction

  function automatic logic [145:0] obs_vec(input int d);
    case (d)
      0:       return {bz[0], dn[0], en16, a16};
      1:       return {bz[1], dn[1], 12'b0, en4, 96'b0, a4};
      default: return {bz[2], dn[2], 14'b0, en2, 112'b0, a2};
    endcase
  endfunction

  // ---------------- driver / test tasks ----------------
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; act[d] = 1'b0; bin[d] = 8'($urandom);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (obs_vec(d) !== 146'b0 || sd[d] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_idle d=%0d c=%0d got=%h sd=%b exp=0", d, c, obs_vec(d), sd[d]);
        end
      end
    end
  endtask

  task automatic test_single_run();
    int cnt [16];
    logic [7:0] row;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    bin[0] = 8'h20; act[0] = 1'b1;
    @(negedge clk);
    act[0] = 1'b0; bin[0] = 8'($urandom);
    for (int k = 0; k <= 31; k++) begin
      n_vec++;
      if (obs_vec(0) !== expect_vec(0)) begin
        n_err++;
        $display("FAIL single_run k=%0d got=%h exp=%h", k, obs_vec(0), expect_vec(0));
      end
      if (k == 0) begin
        n_vec++;
        if (en16 !== 16'h0001 || a16[7:0] !== 8'h20 || bz[0] !== 1'b1) begin
          n_err++;
          $display("FAIL single_k0 en=%h f0=%h busy=%b exp en=0001 f0=20 busy=1", en16, a16[7:0], bz[0]);
        end
      end
      if (k == 15) begin
        n_vec++;
        if (en16 !== 16'hFFFF || a16[7:0] !== 8'h2F || a16[127:120] !== 8'h20) begin
          n_err++;
          $display("FAIL single_k15 en=%h f0=%h f15=%h exp FFFF 2F 20", en16, a16[7:0], a16[127:120]);
        end
      end
      if (k == 30) begin
        n_vec++;
        if (en16 !== 16'h8000 || a16[127:120] !== 8'h2F || dn[0] !== 1'b1) begin
          n_err++;
          $display("FAIL single_k30 en=%h f15=%h done=%b exp 8000 2F 1", en16, a16[127:120], dn[0]);
        end
      end
      if (k == 31) begin
        n_vec++;
        if (obs_vec(0) !== 146'b0) begin
          n_err++;
          $display("FAIL single_after got=%h exp=0", obs_vec(0));
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (en16[i]) begin
          row = 8'h20 + 8'(cnt[i]);
          n_vec++;
          if (a16[i*8 +: 8] !== row) begin
            n_err++;
            $display("FAIL bank_row bank=%0d got=%h exp=%h", i, a16[i*8 +: 8], row);
          end
          cnt[i]++;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (cnt[i] != 16) begin
        n_err++;
        $display("FAIL bank_count bank=%0d got=%0d exp=16", i, cnt[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bin[0] = 8'hFA; act[0] = 1'b1;
    @(negedge clk);
    act[0] = 1'b0;
    for (int k = 0; k <= 31; k++) begin
      n_vec++;
      if (obs_vec(0) !== expect_vec(0)) begin
        n_err++;
        $display("FAIL wrap k=%0d got=%h exp=%h", k, obs_vec(0), expect_vec(0));
      end
      if (k == 5 || k == 15 || k == 30) begin
        n_vec++;
        if ((k == 5  && a16[7:0]     !== 8'hFF) ||
            (k == 15 && a16[7:0]     !== 8'h09) ||
            (k == 30 && a16[127:120] !== 8'h09)) begin
          n_err++;
          $display("FAIL wrap_spot k=%0d f0=%h f15=%h", k, a16[7:0], a16[127:120]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bin[1] = 8'h10; act[1] = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 14; c++) begin
      n_vec++;
      if (obs_vec(1) !== expect_vec(1)) begin
        n_err++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c, obs_vec(1), expect_vec(1));
      end
      if (c == 3) begin
        n_vec++;
        if (en4 !== 4'hF || a4[7:0] !== 8'h13) begin
          n_err++;
          $display("FAIL ignored_start en=%h f0=%h exp F 13", en4, a4[7:0]);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (dn[1] !== 1'b1 || en4 !== 4'h8 || a4[31:24] !== 8'h13) begin
          n_err++;
          $display("FAIL b2b_end done=%b en=%h f3=%h exp 1 8 13", dn[1], en4, a4[31:24]);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (en4 !== 4'h1 || a4[7:0] !== 8'h40 || bz[1] !== 1'b1 || dn[1] !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_restart en=%h f0=%h busy=%b done=%b exp 1 40 1 0", en4, a4[7:0], bz[1], dn[1]);
        end
      end
      if (c == 14) begin
        n_vec++;
        if (bz[1] !== 1'b0 || en4 !== 4'h0) begin
          n_err++;
          $display("FAIL b2b_idle busy=%b en=%h exp 0 0", bz[1], en4);
        end
      end
      if (c == 2)      begin act[1] = 1'b1; bin[1] = 8'h77; end
      else if (c == 6) begin act[1] = 1'b1; bin[1] = 8'h40; end
      else             begin act[1] = 1'b0; bin[1] = 8'($urandom); end
      @(negedge clk);
    end
    act[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    bin[0] = 8'($urandom); act[0] = 1'b1;
    @(negedge clk);
    act[0] = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      n_vec++;
      if (obs_vec(0) !== expect_vec(0)) begin
        n_err++;
        $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs_vec(0), expect_vec(0));
      end
      if (k == 10) begin rst[0] = 1'b1; act[0] = 1'b1; bin[0] = 8'($urandom); end
      @(negedge clk);
    end
    n_vec++;
    if (obs_vec(0) !== 146'b0 || sd[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_clear got=%h sd=%b exp=0", obs_vec(0), sd[0]);
    end
    rst[0] = 1'b0; act[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (obs_vec(0) !== 146'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle got=%h exp=0", obs_vec(0));
    end
    b = 8'($urandom); bin[0] = b; act[0] = 1'b1;
    @(negedge clk);
    act[0] = 1'b0;
    for (int k = 0; k <= 31; k++) begin
      n_vec++;
      if (obs_vec(0) !== expect_vec(0)) begin
        n_err++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, obs_vec(0), expect_vec(0));
      end
      if (k == 0) begin
        n_vec++;
        if (en16 !== 16'h0001 || a16[7:0] !== b) begin
          n_err++;
          $display("FAIL restart_k0 en=%h f0=%h exp 0001 %h", en16, a16[7:0], b);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_small_n();
    bin[2] = 8'h03; act[2] = 1'b1;
    @(negedge clk);
    act[2] = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      n_vec++;
      if (obs_vec(2) !== expect_vec(2)) begin
        n_err++;
        $display("FAIL small_n k=%0d got=%h exp=%h", k, obs_vec(2), expect_vec(2));
      end
      n_vec++;
      if ((k == 0 && {en2, a2, dn[2]} !== {2'b01, 16'h0003, 1'b0}) ||
          (k == 1 && {en2, a2, dn[2]} !== {2'b11, 16'h0304, 1'b0}) ||
          (k == 2 && {en2, a2, dn[2]} !== {2'b10, 16'h0400, 1'b1}) ||
          (k == 3 && {en2, a2, dn[2], bz[2]} !== {2'b00, 16'h0000, 1'b0, 1'b0})) begin
        n_err++;
        $display("FAIL small_n_spot k=%0d en=%b addr=%h done=%b", k, en2, a2, dn[2]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        rst[d] = ($urandom_range(0, 49) == 0);
        act[d] = ($urandom_range(0, 3) == 0);
        bin[d] = 8'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if (obs_vec(d) !== expect_vec(d)) begin
          n_err++;
          $display("FAIL random d=%0d c=%0d got=%h exp=%h", d, c, obs_vec(d), expect_vec(d));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin rst[d] = 1'b0; act[d] = 1'b0; end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin rst[d] = 1'b1; act[d] = 1'b0; bin[d] = 8'h00; end
    test_reset();
    test_single_run();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_small_n();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wr_control.md
# wr_control

Write-side controller for the systolic-array output path. After a start pulse, it generates staggered per-column write enables and per-column row addresses. These capture the array's diagonally skewed result wavefront into the output memory banks, so each column's N results land de-skewed at consecutive rows starting from a common base address. It is the consumer-side counterpart of the read controller that feeds operands into the array. It is started by that controller's write-activate indication.

## Interface
- `width_height`, default 16: array dimension N (columns, and rows per column); legal N ≥ 2.
- `addr_width`, default 8: width of each per-column address field.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `active` input, 1 bit: start request; sampled on each rising edge of `clk`.
- `base_addr` input, `addr_width` bits: first row address; latched on the accepting edge.
- `wr_en` output, N bits: bit i is the write enable for output bank (column) i.
- `wr_addr` output, N*`addr_width` bits: field i (bits [(i+1)*addr_width-1 : i*addr_width]) is the bank-i address.
- `busy` output, 1 bit: high during every cycle of a run.
- `done` output, 1 bit: one-cycle pulse in the last cycle of a run.

## Operation
- States: IDLE and RUN. Run counter k has width $clog2(2N)+1 and runs from 0 to 2N-2.
- IDLE:
  - All outputs are 0.
  - `active`=1 on an edge: latch `base_addr`, set k=0, enter RUN.
- RUN, in cycle k:
  - `wr_en[i]` = 1 iff i ≤ k ≤ i+N-1. Column i therefore writes for N consecutive cycles, starting k=i.
  - `wr_addr` field i = (base + k - i) mod 2^addr_width while `wr_en[i]`=1; the field is 0 otherwise.
  - `busy`=1.
  - `done`=1 only when k=2N-2.
  - Each edge advances k by 1. At the edge ending k=2N-2, go to IDLE.
- `active` during RUN (any k < 2N-2) is ignored. The latched base is unchanged.
- Back-to-back: `active`=1 on the edge ending k=2N-2 starts a new run. The next cycle is k=0 with the new base; no idle gap; `busy` stays 1.
- Address arithmetic wraps modulo 2^addr_width. No saturation, no error flag.
- `reset`=1 on an edge, in any state or cycle:
  - next cycle is IDLE, k=0, latched base=0;
  - all outputs are 0;
  - `reset` overrides a simultaneous `active`.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `busy`=0, `done`=0.
- All outputs are registered. They change only on rising edges and are glitch-free to the memory banks.
- Latency:
  - The edge sampling `active`=1 in IDLE is followed immediately by cycle k=0, with `wr_en`=...0001 and field 0 = base.
  - A run is exactly 2N-1 cycles (31 for N=16).
- Last write per column: column i at k=i+N-1. Column N-1 at k=2N-2, coincident with `done`.
- Per cycle, the number of set `wr_en` bits is min(k+1, N, 2N-1-k).

## Test plan
- Reset then idle, N=16: hold `reset` 2 cycles, then `active`=0 for 10 cycles → all outputs 0 throughout.
- Single run, N=16, base=0x20: `active` pulse.
  - k=0: `wr_en`=0x0001, field0=0x20.
  - k=15: `wr_en`=0xFFFF, field0=0x2F, field15=0x20.
  - k=30: `wr_en`=0x8000, field15=0x2F, `done`=1.
  - Next cycle: all 0.
  - Every bank gets 16 writes at rows 0x20..0x2F.
- Wrap, N=16, base=0xFA: field0 is 0xFF at k=5 and 0x09 at k=15. Field15 is 0x09 at k=30.
- Ignored and back-to-back starts, N=4:
  - `active` at k=2 → no effect; run ends at k=6.
  - `active`=1 on the edge ending k=6 with base=0x40 → next cycle k=0, `wr_en`=0x1, field0=0x40, `busy` held 1.
- Reset mid-run, N=16, at k=10 with `active` also high → next cycle all outputs 0, IDLE. A later `active` starts cleanly at k=0.
- Small N=2, base=0x03: k=0 `wr_en`=01 (f0=3); k=1 `wr_en`=11 (f0=4, f1=3); k=2 `wr_en`=10 (f1=4), `done`=1.
